// File: rtl/a51_stream_cipher.sv
// A5/1 stream-cipher engine: loads key and frame, warms up, then XORs DATA_W-bit
// words with the keystream (MSB first) over valid/ready, optionally re-keying per burst.
module a51_stream_cipher #(
  parameter int KEY_LEN   = 64,
  parameter int FRAME_LEN = 22,
  parameter int WARMUP    = 100,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_LEN-1:0]   key_in,
  input  logic [FRAME_LEN-1:0] frame_in,
  output logic                 busy,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [DATA_W-1:0]    din,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [DATA_W-1:0]    dout,
  output logic [FRAME_LEN-1:0] frame_cur
);

  localparam int CMAX_A = (KEY_LEN > FRAME_LEN) ? KEY_LEN : FRAME_LEN;
  localparam int CMAX_B = (WARMUP > DATA_W) ? WARMUP : DATA_W;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = $clog2(CMAX);
  localparam int KIW    = $clog2(KEY_LEN);
  localparam int FIW    = $clog2(FRAME_LEN);

  localparam logic [CW-1:0] KEY_LAST   = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_W - 1);
  localparam logic [31:0]   BURST_BITS = 32'(BURST_LEN);
  localparam logic          RELOAD_EN  = (BURST_LEN != 0);

  localparam logic [18:0] R1_TAPS = 19'h72000;
  localparam logic [21:0] R2_TAPS = 22'h300000;
  localparam logic [22:0] R3_TAPS = 23'h700080;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_FRAME, S_WARM, S_READY, S_GEN, S_OUT
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [31:0]            bits_q;
  logic [KEY_LEN-1:0]     key_q;
  logic [FRAME_LEN-1:0]   frame_cur_q;
  logic [18:0]            r1_q, r1_d;
  logic [21:0]            r2_q, r2_d;
  logic [22:0]            r3_q, r3_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DATA_W-1:0]      dout_q;
  logic                   busy_q, din_ready_q, dout_valid_q;

  logic                   ld_bit, maj, clk1, clk2, clk3, ks;

  // Register stepping: all three clocked with a load bit during KEY/FRAME,
  // majority-clocked during WARM/GEN, held otherwise.
  always_comb begin
    ld_bit = 1'b0;
    clk1   = 1'b0;
    clk2   = 1'b0;
    clk3   = 1'b0;
    maj    = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    unique case (state_q)
      S_KEY: begin
        ld_bit = key_q[cnt_q[KIW-1:0]];
        clk1 = 1'b1; clk2 = 1'b1; clk3 = 1'b1;
      end
      S_FRAME: begin
        ld_bit = frame_cur_q[cnt_q[FIW-1:0]];
        clk1 = 1'b1; clk2 = 1'b1; clk3 = 1'b1;
      end
      S_WARM, S_GEN: begin
        clk1 = (r1_q[8]  == maj);
        clk2 = (r2_q[10] == maj);
        clk3 = (r3_q[10] == maj);
      end
      default: ;
    endcase
    r1_d = clk1 ? {r1_q[17:0], ^(r1_q & R1_TAPS) ^ ld_bit} : r1_q;
    r2_d = clk2 ? {r2_q[20:0], ^(r2_q & R2_TAPS) ^ ld_bit} : r2_q;
    r3_d = clk3 ? {r3_q[21:0], ^(r3_q & R3_TAPS) ^ ld_bit} : r3_q;
    ks   = r1_d[18] ^ r2_d[21] ^ r3_d[22];
    // Rotating the word once per keystream bit lines bit k up with din[DATA_W-1-k]
    // and leaves the word in its original order after DATA_W steps.
    data_d = {data_q[DATA_W-2:0], data_q[DATA_W-1] ^ ks};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bits_q       <= '0;
      key_q        <= '0;
      frame_cur_q  <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      r3_q         <= '0;
      data_q       <= '0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            key_q       <= key_in;
            frame_cur_q <= frame_in;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            cnt_q       <= '0;
            bits_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_KEY;
          end
        end
        S_KEY: begin
          r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
          if (cnt_q == KEY_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FRAME;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FRAME: begin
          r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
          if (cnt_q == FRAME_LAST) begin
            cnt_q   <= '0;
            state_q <= S_WARM;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WARM: begin
          r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
          if (cnt_q == WARM_LAST) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            din_ready_q <= 1'b1;
            state_q     <= S_READY;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_READY: begin
          if (din_valid) begin
            data_q      <= din;
            cnt_q       <= '0;
            din_ready_q <= 1'b0;
            state_q     <= S_GEN;
          end
        end
        S_GEN: begin
          r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
          data_q <= data_d;
          if (cnt_q == DATA_LAST) begin
            cnt_q        <= '0;
            dout_q       <= data_d;
            dout_valid_q <= 1'b1;
            bits_q       <= bits_q + 32'(DATA_W);
            state_q      <= S_OUT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_OUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            if (RELOAD_EN && (bits_q == BURST_BITS)) begin
              frame_cur_q <= frame_cur_q + FRAME_LEN'(1);
              r1_q        <= '0;
              r2_q        <= '0;
              r3_q        <= '0;
              cnt_q       <= '0;
              bits_q      <= '0;
              busy_q      <= 1'b1;
              state_q     <= S_KEY;
            end else begin
              din_ready_q <= 1'b1;
              state_q     <= S_READY;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign frame_cur  = frame_cur_q;

endmodule

// File: tb/tb_a51_stream_cipher.sv
// Self-checking bench for a51_stream_cipher: directed steps with random data,
// checked against an arithmetic A5/1 keystream model.
module tb_a51_stream_cipher;

  localparam logic [63:0] GK = 64'hEFCDAB8967452312;
  localparam logic [21:0] GF = 22'h134;
  localparam int          LIM = 1000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, din_valid = 1'b0, dout_ready = 1'b1;
  logic [63:0] key_in = '0;
  logic [21:0] frame_in = '0;
  logic [7:0]  din = '0;

  logic        busy0, dr0, dv0, busy1, dr1, dv1;
  logic [7:0]  dout0, dout1;
  logic [21:0] fc0, fc1;

  a51_stream_cipher dut0 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .frame_in(frame_in),
    .busy(busy0), .din_valid(din_valid), .din_ready(dr0), .din(din),
    .dout_valid(dv0), .dout_ready(dout_ready), .dout(dout0), .frame_cur(fc0)
  );

  a51_stream_cipher #(.BURST_LEN(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .frame_in(frame_in),
    .busy(busy1), .din_valid(din_valid), .din_ready(dr1), .din(din),
    .dout_valid(dv1), .dout_ready(dout_ready), .dout(dout1), .frame_cur(fc1)
  );

  logic        sel = 1'b0;
  logic        busy, dr, dv;
  logic [7:0]  dout;
  logic [21:0] fc;
  always_comb begin
    busy = sel ? busy1 : busy0;
    dr   = sel ? dr1   : dr0;
    dv   = sel ? dv1   : dv0;
    dout = sel ? dout1 : dout0;
    fc   = sel ? fc1   : fc0;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] ksb [0:31];
  logic [7:0] golden [0:3];
  logic [7:0] ct [0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One A5/1 register step: shift up, feed back the XOR of the tap bits plus the load bit.
  function automatic int unsigned step_reg(input int unsigned v, input int idx, input int unsigned in);
    int unsigned fb;
    int unsigned len;
    case (idx)
      0: begin fb = (v >> 13) ^ (v >> 16) ^ (v >> 17) ^ (v >> 18); len = 19; end
      1: begin fb = (v >> 20) ^ (v >> 21);                         len = 22; end
      default: begin fb = (v >> 7) ^ (v >> 20) ^ (v >> 21) ^ (v >> 22); len = 23; end
    endcase
    fb = (fb ^ in) & 1;
    return ((v << 1) | fb) & ((32'd1 << len) - 1);
  endfunction

  task automatic maj_step(inout int unsigned r [3]);
    int unsigned c [3];
    int unsigned m;
    c[0] = (r[0] >> 8) & 1;
    c[1] = (r[1] >> 10) & 1;
    c[2] = (r[2] >> 10) & 1;
    m = (c[0] + c[1] + c[2] >= 2) ? 1 : 0;
    for (int j = 0; j < 3; j++)
      if (c[j] == m) r[j] = step_reg(r[j], j, 0);
  endtask

  task automatic gen_ks(input logic [63:0] k, input logic [21:0] f);
    int unsigned r [3];
    int unsigned b;
    r = '{0, 0, 0};
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 3; j++) r[j] = step_reg(r[j], j, int'(k[i]));
    for (int i = 0; i < 22; i++)
      for (int j = 0; j < 3; j++) r[j] = step_reg(r[j], j, int'(f[i]));
    for (int i = 0; i < 100; i++) maj_step(r);
    for (int i = 0; i < 256; i++) begin
      maj_step(r);
      b = ((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 1;
      ksb[i / 8][7 - (i % 8)] = b[0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [63:0] k, input logic [21:0] f, output int lat);
    key_in   = k;
    frame_in = f;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!dr && lat < LIM) begin
      tick();
      lat++;
    end
  endtask

  task automatic xfer(input logic [7:0] v, output logic [7:0] o);
    int n = 0;
    while (!dr && n < LIM) begin tick(); n++; end
    if (n >= LIM) check("din_ready_timeout", dr, 1);
    din = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n = 0;
    while (!dv && n < 100) begin tick(); n++; end
    if (n >= 100) check("dout_valid_timeout", dv, 1);
    o = dout;
    if (dout_ready) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_din_ready"}, dr, 0);
    check({tag, "_dout_valid"}, dv, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_frame_cur"}, fc, 0);
  endtask

  task automatic run_golden(input string tag);
    int lat;
    logic [7:0] o;
    do_start(GK, GF, lat);
    check({tag, "_latency"}, lat, 187);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, o);
      check({tag, "_byte"}, o, golden[i]);
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] o, v, held;
    logic [63:0] rk;
    logic [21:0] rf;

    golden[0] = 8'h53; golden[1] = 8'h4E; golden[2] = 8'hAA; golden[3] = 8'h58;

    // Reset state
    do_reset();
    sel = 1'b0; check_zero("reset0");
    sel = 1'b1; check_zero("reset1");
    sel = 1'b0;

    // Golden vector, including start-to-ready latency
    run_golden("golden");
    check("golden_frame_cur", fc, GF);
    check("golden_busy_after", busy, 0);

    // Start while in READY is ignored: same key keeps producing the next bytes
    gen_ks(GK, GF);
    key_in = '0; frame_in = '0; start = 1'b1; tick(); start = 1'b0;
    check("start_ignored_frame", fc, GF);
    xfer(8'h00, o);
    check("start_ignored_byte", o, ksb[4]);

    // All-zero key and frame
    do_reset();
    do_start('0, '0, lat);
    check("zero_ready", dr, 1);
    xfer(8'hA5, o); check("zero_a5", o, 8'hA5);
    xfer(8'h3C, o); check("zero_3c", o, 8'h3C);

    // Round trip: encrypt 0..15, then decrypt the ciphertext
    do_reset();
    gen_ks(GK, GF);
    do_start(GK, GF, lat);
    for (int i = 0; i < 16; i++) begin
      v = 8'(i);
      xfer(v, ct[i]);
      check("rt_encrypt", ct[i], ksb[i] ^ v);
    end
    do_reset();
    do_start(GK, GF, lat);
    for (int i = 0; i < 16; i++) begin
      xfer(ct[i], o);
      check("rt_decrypt", o, i);
    end

    // Random key, frame and data against the model
    for (int t = 0; t < 2; t++) begin
      rk = {$urandom(), $urandom()};
      rf = 22'($urandom());
      gen_ks(rk, rf);
      do_reset();
      do_start(rk, rf, lat);
      check("rand_latency", lat, 187);
      for (int i = 0; i < 6; i++) begin
        v = 8'($urandom());
        xfer(v, o);
        check("rand_byte", o, ksb[i] ^ v);
      end
    end

    // Backpressure on the first word
    do_reset();
    do_start(GK, GF, lat);
    dout_ready = 1'b0;
    xfer(8'h00, held);
    check("bp_first", held, golden[0]);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", dv, 1);
      check("bp_dout", dout, held);
      check("bp_din_ready", dr, 0);
    end
    dout_ready = 1'b1;
    tick();
    for (int i = 1; i < 4; i++) begin
      xfer(8'h00, o);
      check("bp_byte", o, golden[i]);
    end

    // Reset in the middle of warm-up, then golden again
    do_reset();
    key_in = GK; frame_in = GF; start = 1'b1; tick(); start = 1'b0;
    repeat (100) tick();
    check("warm_busy_before", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("rst_warm");
    run_golden("after_warm_rst");

    // Reset in the middle of word generation
    din = 8'h00; din_valid = 1'b1; tick(); din_valid = 1'b0;
    tick(); tick();
    check("gen_dout_before", dout, golden[3]);
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("rst_gen");
    repeat (12) tick();
    check("rst_gen_no_emit", dv, 0);
    run_golden("after_gen_rst");

    // Automatic re-key with frame wrap
    sel = 1'b1;
    do_reset();
    gen_ks(GK, 22'h3FFFFF);
    do_start(GK, 22'h3FFFFF, lat);
    check("rekey_latency", lat, 187);
    for (int i = 0; i < 2; i++) begin
      v = 8'($urandom());
      xfer(v, o);
      check("rekey_word", o, ksb[i] ^ v);
    end
    check("rekey_busy", busy, 1);
    check("rekey_frame_wrap", fc, 0);
    check("rekey_din_ready", dr, 0);
    gen_ks(GK, 22'h000000);
    v = 8'($urandom());
    xfer(v, o);
    check("rekey_word3", o, ksb[0] ^ v);
    v = 8'($urandom());
    xfer(v, o);
    check("rekey_word4", o, ksb[1] ^ v);
    check("rekey_second_frame", fc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a51_stream_cipher.md
Name: a51_stream_cipher

Overview:
- Self-contained, parametrised A5/1 stream-cipher engine. Supersedes the bit-serial encrypt datapath, in which the key, frame and majority bits were sequenced by the bench.
- Internally sequences key load, frame load and warm-up, then XORs DATA_W-bit words with the keystream over a valid/ready handshake.
- Optionally re-keys automatically with frame+1 after every BURST_LEN keystream bits.
- Sits between the image-bit source and the ciphertext sink. Decryption is the same block.

Parameters:
- KEY_LEN, 64, secret key bits loaded; key_in[0] is loaded first.
- FRAME_LEN, 22, frame (public key) bits loaded; frame_in[0] is loaded first.
- WARMUP, 100, majority-clocked cycles whose output is discarded.
- DATA_W, 8, data word width; keystream is applied MSB first.
- BURST_LEN, 0, keystream bits per frame before auto-reload; 0 disables reload. Must be a multiple of DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches key_in/frame_in and begins loading
- key_in  in  KEY_LEN  secret key
- frame_in  in  FRAME_LEN  initial frame number
- busy  out  1  high in KEY, FRAME, WARM
- din_valid  in  1  input word valid
- din_ready  out  1  high only in READY
- din  in  DATA_W  plaintext/ciphertext word
- dout_valid  out  1  output word valid
- dout_ready  in  1  sink accepts dout
- dout  out  DATA_W  din XOR keystream
- frame_cur  out  FRAME_LEN  frame number currently in use

Behaviour:
- Reset: FSM=IDLE; R1/R2/R3, counters, dout, frame_cur all 0; busy=din_ready=dout_valid=0. rst mid-operation aborts at once; no partial word is emitted.
- Registers: R1 19b, taps 13,16,17,18, clock bit 8. R2 22b, taps 20,21, clock bit 10. R3 23b, taps 7,20,21,22, clock bit 10.
- Clocking a register: shift toward the MSB; new bit0 = XOR of its taps (XOR the load bit in during KEY/FRAME).
- Keystream bit = R1[18]^R2[21]^R3[22], sampled after the clocking in the same cycle.
- Majority clocking: m = maj(R1[8],R2[10],R3[10]); clock each register whose clock bit equals m.
- IDLE: wait for start. On start, latch key_in to key_q and frame_in to frame_cur, zero R1-R3, go to KEY. start is ignored in every other state.
- KEY: KEY_LEN cycles, all three registers clocked; bit i = key_q[i]. Then FRAME.
- FRAME: FRAME_LEN cycles, all registers clocked; bit i = frame_cur[i]. Then WARM.
- WARM: WARMUP majority cycles, output discarded. Then READY.
- Latency from start to din_ready=1 is KEY_LEN+FRAME_LEN+WARMUP+1 cycles (187 at defaults).
- READY: din_ready=1. On din_valid&din_ready, capture din and go to GEN.
- GEN: DATA_W majority cycles. Keystream bit k (k=0 first) XORs din[DATA_W-1-k]. Then OUT.
- OUT: dout_valid=1; dout is stable until dout_ready. On the handshake, clear dout_valid, then:
  - if BURST_LEN≠0 and total bits since the last load = BURST_LEN: frame_cur += 1 (mod 2^FRAME_LEN), zero R1-R3, go to KEY (reuse key_q);
  - otherwise go to READY.
- Throughput: at most one word per DATA_W+2 cycles.
- A start pulse in READY/GEN/OUT has no effect. Users re-key only by rst then start.
- All-zero key and frame give an all-zero keystream. This is legal; no special handling.

Test Plan:
- Golden vector: key_in=64'hEFCDAB8967452312, frame_in=22'h134, din=0x00 ×4, dout_ready=1 -> dout = 0x53, 0x4E, 0xAA, 0x58. din_ready rises exactly 187 cycles after the start pulse.
- Zero key/frame: key_in=0, frame_in=0, din=0xA5, 0x3C -> dout = 0xA5, 0x3C.
- Round trip: encrypt 0x00..0x0F with the golden key, then rst, start again and feed the ciphertext -> dout = 0x00..0x0F.
- Backpressure: hold dout_ready=0 for 20 cycles in OUT -> dout_valid stays 1, dout is stable, din_ready=0. After release, the stream matches the no-stall run.
- Auto re-key: BURST_LEN=16, frame_in=22'h3FFFFF -> after 2 words busy rises; frame_cur = 0 (wrap); word 3 equals a fresh run started with frame_in=0.
- Reset mid-WARM and mid-GEN -> all outputs are 0 next cycle. A following start reproduces the golden bytes.
